program_loader: RTL and testbench

- Upstream stage of the 8-bit single-cycle core.
- Receives a program as a byte stream over a valid/ready handshake and writes it into the loadable port of instruction memory, starting at address 0.
- Holds the core in reset until the load completes.
- Replaces hard-coded instruction ROM contents for bring-up and test.

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/loader_checksum.sv | 36 +++
 rtl/program_loader.sv | 155 +++++++++++++++
 tb/tb_program_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and default widths for the program loader
package program_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CHK,
      DONE,
      ERR
   } state_e;

   localparam int LEN_ZERO_FULL = 256;
   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_DEPTH     = 256;

endpackage

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - 8-bit modular byte accumulator with clear, add and zero check
module loader_checksum (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       add,
   input  logic [7:0] data,
   output logic       zero_with
);

   logic [7:0] sum_q;
   logic [7:0] sum_d;
   logic [7:0] total;

   always_comb begin
      sum_d = sum_q;
      if (clear) begin
         sum_d = 8'd0;
      end else if (add) begin
         sum_d = sum_q + data;
      end
   end

   // Checksum byte is judged against the sum it would produce, so no extra cycle is needed.
   assign total     = sum_q + data;
   assign zero_with = (total == 8'd0);

   always_ff @(posedge clock) begin
      if (reset) begin
         sum_q <= 8'd0;
      end else begin
         sum_q <= sum_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed program into instruction memory, holding the core meanwhile
// Optional trailing checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = ADDR_W + 1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam state_e AFTER_DATA = CHK;
`else
   localparam state_e AFTER_DATA = DONE;
`endif

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0]  len_q, len_d;
   logic              in_ready_q, in_ready_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              accept;
   logic [DATA_W:0]   len_val;

   assign accept  = in_valid && in_ready_q;
   assign cnt_inc = cnt_q + 1'b1;
   // A zero length byte stands for a full 256-word program.
   assign len_val = (in_data == '0) ? (DATA_W+1)'(LEN_ZERO_FULL) : {1'b0, in_data};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic chk_ok;

   loader_checksum u_checksum (
      .clock     (clock),
      .reset     (reset),
      .clear     ((state_q != LEN) && (state_d == LEN)),
      .add       ((state_q == DATA) && accept),
      .data      (in_data[7:0]),
      .zero_with (chk_ok)
   );
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = LEN;
         end
         LEN: begin
            if (accept) begin
               if (int'(len_val) > DEPTH) begin
                  state_d = ERR;
               end else begin
                  len_d   = CNT_W'(len_val);
                  cnt_d   = '0;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               imem_we_d    = 1'b1;
               imem_addr_d  = cnt_q[ADDR_W-1:0];
               imem_wdata_d = in_data;
               cnt_d        = cnt_inc;
               if (cnt_inc == len_q) state_d = AFTER_DATA;
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         CHK: begin
            if (accept) state_d = chk_ok ? DONE : ERR;
         end
`endif
         DONE, ERR: begin
            if (start) begin
               state_d = LEN;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Status outputs are registered images of the state being entered.
      in_ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
      busy_d     = in_ready_d;
      done_d     = (state_d == DONE);
      err_d      = (state_d == ERR);
      cpu_hold_d = (state_d != DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         len_q        <= '0;
         in_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_hold_q   <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         in_ready_q   <= in_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader (full-depth and 16-word instances)
module tb_program_loader;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;
   typedef logic [7:0] bq_t[$];

   logic       clock = 1'b0;
   logic       reset_b, start_b, reset_s, start_s;
   logic       in_valid;
   logic [7:0] in_data;

   logic       rdy_b, we_b, hold_b, busy_b, done_b, err_b;
   logic [7:0] addr_b, wdata_b;
   logic       rdy_s, we_s, hold_s, busy_s, done_s, err_s;
   logic [3:0] addr_s;
   logic [7:0] wdata_s;

   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc   = 0;
   wr_t wq_b[$];
   wr_t wq_s[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   program_loader #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
      .clock(clock), .reset(reset_b), .start(start_b), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
      .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .err(err_b)
   );

   program_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut_small (
      .clock(clock), .reset(reset_s), .start(start_s), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_s), .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s),
      .cpu_hold(hold_s), .busy(busy_s), .done(done_s), .err(err_s)
   );

   always @(negedge clock) begin
      if (we_b === 1'b1) wq_b.push_back('{cyc, int'(addr_b), int'(wdata_b)});
      if (we_s === 1'b1) wq_s.push_back('{cyc, int'(addr_s), int'(wdata_s)});
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: summary not reached in time");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] status(input int sel);
      if (sel != 0) return {done_s, err_s, hold_s, busy_s, rdy_s};
      return {done_b, err_b, hold_b, busy_b, rdy_b};
   endfunction

   function automatic logic ready_of(input int sel);
      return (sel != 0) ? rdy_s : rdy_b;
   endfunction

   function automatic int gap_len(input int mode, input int idx);
      if (mode == 1) return int'($urandom_range(0, 2));
      if (mode == 2) return (idx == 1) ? 2 : ((idx == 2) ? 1 : 0);
      return 0;
   endfunction

   function automatic bq_t rand_bytes(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start(input int sel);
      if (sel != 0) start_s = 1'b1;
      else          start_b = 1'b1;
      tick();
      start_b = 1'b0;
      start_s = 1'b0;
   endtask

   task automatic do_gap(input int sel, input int n, input bit rand_start);
      repeat (n) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         if (rand_start && ($urandom_range(0, 1) == 1)) begin
            if (sel != 0) start_s = 1'b1;
            else          start_b = 1'b1;
         end
         tick();
         start_b = 1'b0;
         start_s = 1'b0;
      end
   endtask

   task automatic send_byte(input int sel, input logic [7:0] b, input string tag);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clock);
         if (ready_of(sel) === 1'b1) ok = 1'b1;
         @(posedge clock);
         #1;
      end
      if (!ok) check_eq({tag, "_accept_timeout"}, 32'(ok), 32'd1);
      in_valid = 1'b0;
   endtask

   // Reference behaviour: L (0 -> 256) words land at addresses 0..L-1 unless L exceeds the depth.
   task automatic run_load(input int sel, input int lbyte, input bq_t data, input int gap_mode,
                           input int chk_delta, input bit rand_start, input string tag);
      int         lact, depth;
      bit         exp_err;
      logic [7:0] sum, c;
      wr_t        got[$];
      lact  = (lbyte == 0) ? 256 : lbyte;
      depth = (sel != 0) ? 16 : 256;
      wq_b.delete();
      wq_s.delete();
      pulse_start(sel);
      send_byte(sel, 8'(lbyte), tag);
      if (lact > depth) begin
         tick();
         check_eq({tag, "_status"}, 32'(status(sel)), 32'b01100);
         got = (sel != 0) ? wq_s : wq_b;
         check_eq({tag, "_nwrites"}, 32'(got.size()), 32'd0);
         return;
      end
      sum = 8'd0;
      for (int i = 0; i < lact; i++) begin
         do_gap(sel, gap_len(gap_mode, i), rand_start);
         send_byte(sel, data[i], tag);
         sum = sum + data[i];
      end
      exp_err = 1'b0;
      c = 8'(chk_delta - int'(sum));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      do_gap(sel, gap_len(gap_mode, 0), rand_start);
      send_byte(sel, c, tag);
      exp_err = (c + sum) != 8'd0;
`endif
      tick();
      tick();
      check_eq({tag, "_status"}, 32'(status(sel)), 32'({~exp_err, exp_err, exp_err, 2'b00}));
      got = (sel != 0) ? wq_s : wq_b;
      check_eq({tag, "_nwrites"}, 32'(got.size()), 32'(lact));
      for (int i = 0; i < got.size() && i < lact; i++) begin
         check_eq($sformatf("%s_addr%0d", tag, i), 32'(got[i].addr), 32'(i));
         check_eq($sformatf("%s_data%0d", tag, i), 32'(got[i].data), 32'(data[i]));
      end
   endtask

   initial begin
      bq_t q;
      reset_b  = 1'b1;
      reset_s  = 1'b1;
      start_b  = 1'b0;
      start_s  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      repeat (3) tick();
      reset_b = 1'b0;
      reset_s = 1'b0;
      @(negedge clock);
      check_eq("rst_in_ready", 32'(rdy_b), 32'd0);
      check_eq("rst_imem_we", 32'(we_b), 32'd0);
      check_eq("rst_imem_addr", 32'(addr_b), 32'd0);
      check_eq("rst_imem_wdata", 32'(wdata_b), 32'd0);
      check_eq("rst_cpu_hold", 32'(hold_b), 32'd1);
      check_eq("rst_busy", 32'(busy_b), 32'd0);
      check_eq("rst_done", 32'(done_b), 32'd0);
      check_eq("rst_err", 32'(err_b), 32'd0);
      tick();

      q = '{8'hA1, 8'h22, 8'h63};
      run_load(0, 3, q, 0, 0, 1'b0, "l3_held");
      if (wq_b.size() == 3) begin
         check_eq("l3_held_gap1", 32'(wq_b[1].cyc - wq_b[0].cyc), 32'd1);
         check_eq("l3_held_gap2", 32'(wq_b[2].cyc - wq_b[1].cyc), 32'd1);
      end
      run_load(0, 3, q, 2, 0, 1'b0, "l3_toggle");
      if (wq_b.size() == 3) begin
         check_eq("l3_toggle_gap1", 32'(wq_b[1].cyc - wq_b[0].cyc), 32'd3);
         check_eq("l3_toggle_gap2", 32'(wq_b[2].cyc - wq_b[1].cyc), 32'd2);
      end

      run_load(1, 20, q, 0, 0, 1'b0, "small_l20");
      run_load(1, 2, rand_bytes(2), 1, 0, 1'b0, "small_l2");
      run_load(1, 16, rand_bytes(16), 1, 0, 1'b1, "small_l16");
      run_load(1, 17, q, 0, 0, 1'b0, "small_l17");

      q.delete();
      for (int i = 0; i < 256; i++) q.push_back(8'(i + 1));
      run_load(0, 0, q, 0, 0, 1'b0, "l256");
      if (wq_b.size() > 0) begin
         check_eq("l256_last_addr", 32'(wq_b[wq_b.size()-1].addr), 32'hFF);
         check_eq("l256_last_data", 32'(wq_b[wq_b.size()-1].data), 32'h00);
      end

      wq_b.delete();
      q = rand_bytes(5);
      pulse_start(0);
      send_byte(0, 8'd5, "midrst");
      send_byte(0, q[0], "midrst");
      send_byte(0, q[1], "midrst");
      in_valid = 1'b1;
      in_data  = q[2];
      reset_b  = 1'b1;
      tick();
      reset_b  = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      check_eq("midrst_status", 32'(status(0)), 32'b00100);
      check_eq("midrst_we", 32'(we_b), 32'd0);
      repeat (5) tick();
      check_eq("midrst_nwrites", 32'(wq_b.size()), 32'd2);
      run_load(0, 5, rand_bytes(5), 1, 0, 1'b1, "post_rst");

      start_b = 1'b1;
      reset_b = 1'b1;
      tick();
      start_b = 1'b0;
      reset_b = 1'b0;
      @(negedge clock);
      check_eq("start_rst_status", 32'(status(0)), 32'b00100);
      tick();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      q = '{8'h10, 8'h20};
      run_load(0, 2, q, 0, 0, 1'b0, "chk_good");
      run_load(0, 2, q, 0, 1, 1'b0, "chk_bad");
`endif

      for (int k = 0; k < 10; k++) begin
         int sel, l, n;
         sel = int'($urandom_range(0, 1));
         l   = (sel != 0) ? int'($urandom_range(1, 24)) : int'($urandom_range(0, 60));
         n   = (l == 0) ? 256 : l;
         run_load(sel, l, rand_bytes(n), 1, int'($urandom_range(0, 1)), 1'b1, $sformatf("rand%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
